// File: rtl/qmc_fx_pkg.sv
// qmc_fx_pkg
//   Shared fixed-point definitions for the QMC-LSM path generator stages.
//   Provides the default Q(16.16) word format, the rounding / saturation
//   constants derived from it, and the path-stepper FSM state encoding.
package qmc_fx_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_QINT  = 16;
    localparam int FX_QFRAC = FX_WIDTH - FX_QINT;

    // Half an LSB of the product's discarded fraction (round half-up bias)
    // and the all-ones saturation value for the default word.
    localparam logic [2*FX_WIDTH-1:0] FX_ROUND_HALF = 64'(1) << (FX_QFRAC - 1);
    localparam logic [FX_WIDTH-1:0]   FX_SAT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } stepper_state_t;

endpackage

// File: rtl/fx_umul_round_sat.sv
// fx_umul_round_sat
//   Registered unsigned fixed-point multiply: y = sat(round_half_up(a*b >> QFRAC)).
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset (clears valid/result/flag)
//     vld_i        : operands valid
//     a_i, b_i     : unsigned Q(WIDTH-QFRAC . QFRAC) operands
//     res_nxt_o    : combinational result, for callers that must write it back
//                    on the same edge the registered result updates
//     res_o, ovf_o : registered result and its saturation flag
//     vld_o        : registered valid, one cycle after vld_i
module fx_umul_round_sat
    import qmc_fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int QFRAC = FX_QFRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_nxt_o,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o,
    output logic             vld_o
);

    // One guard bit so the rounding bias can never wrap the product.
    localparam int PW = 2 * WIDTH + 1;

    if (QFRAC < 1 || QFRAC >= WIDTH) begin : g_bad_qfrac
        $error("fx_umul_round_sat: QFRAC must be in 1..WIDTH-1");
    end

    function automatic logic [PW-1:0] round_half_up(input logic [2*WIDTH-1:0] p);
        logic [PW-1:0] half;
        half            = '0;
        half[QFRAC-1]   = 1'b1;
        return ({1'b0, p} + half) >> QFRAC;
    endfunction

    // Returns {overflow, value}.
    function automatic logic [WIDTH:0] saturate(input logic [PW-1:0] r);
        if (|r[PW-1:WIDTH]) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sat;

    always_comb begin
        prod      = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        sat       = saturate(round_half_up(prod));
        res_nxt_o = sat[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_o <= 1'b0;
            res_o <= '0;
            ovf_o <= 1'b0;
        end else begin
            vld_o <= vld_i;
            if (vld_i) begin
                res_o <= sat[WIDTH-1:0];
                ovf_o <= sat[WIDTH];
            end
        end
    end

endmodule

// File: rtl/gbm_path_stepper.sv
// gbm_path_stepper
//   Holds the current price of every simulated path and multiplies it by the
//   incoming per-step growth factor, writing the product back and streaming it
//   with its path/step tag. Factors arrive path-fastest, one per valid_in.
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     start, s0           : run start pulse and initial spot (sampled on accept)
//     valid_in, exp_factor: growth factor stream (no backpressure)
//     price_out, path_idx_out, step_idx_out, valid_out : tagged result stream
//     busy, done          : run in progress / one-cycle end-of-run pulse
//     overflow_err        : sticky, a product saturated this run
//     drop_err            : sticky, a factor arrived outside RUN
module gbm_path_stepper
    import qmc_fx_pkg::*;
#(
    parameter int WIDTH     = FX_WIDTH,
    parameter int QINT      = FX_QINT,
    parameter int QFRAC     = WIDTH - QINT,
    parameter int NUM_PATHS = 64,
    parameter int NUM_STEPS = 52,
    localparam int PIW = $clog2(NUM_PATHS),
    localparam int SIW = $clog2(NUM_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] s0,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] exp_factor,
    output logic [WIDTH-1:0] price_out,
    output logic [PIW-1:0]   path_idx_out,
    output logic [SIW-1:0]   step_idx_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic             overflow_err,
    output logic             drop_err
);

    if (NUM_PATHS < 2) begin : g_bad_paths
        $error("gbm_path_stepper: NUM_PATHS must be >= 2");
    end
    if (NUM_STEPS < 1) begin : g_bad_steps
        $error("gbm_path_stepper: NUM_STEPS must be >= 1");
    end
    if (QINT + QFRAC != WIDTH) begin : g_bad_q
        $error("gbm_path_stepper: QINT + QFRAC must equal WIDTH");
    end

    stepper_state_t   state_q, state_d;
    logic [PIW-1:0]   path_cnt_q, path_cnt_d;
    logic [SIW-1:0]   step_cnt_q, step_cnt_d;
    logic             ovf_err_q, ovf_err_d;
    logic             drop_err_q, drop_err_d;
    logic [WIDTH-1:0] s0_q;
    logic [WIDTH-1:0] mem [NUM_PATHS];

    logic             accept, last_path, last_step;
    logic             vld_p1, last_p1;
    logic [WIDTH-1:0] price_p1, factor_p1;
    logic [PIW-1:0]   path_p1, path_p2;
    logic [SIW-1:0]   step_p1, step_p2;
    logic             vld_p2, last_p2, ovf_p2;
    logic [WIDTH-1:0] res_nxt, res_p2;

    assign accept    = (state_q == ST_RUN) && valid_in;
    assign last_path = (path_cnt_q == PIW'(NUM_PATHS - 1));
    assign last_step = (step_cnt_q == SIW'(NUM_STEPS - 1));

    always_comb begin
        state_d    = state_q;
        path_cnt_d = path_cnt_q;
        step_cnt_d = step_cnt_q;
        ovf_err_d  = ovf_err_q;
        drop_err_d = drop_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_INIT;
                    path_cnt_d = '0;
                    step_cnt_d = '0;
                    ovf_err_d  = 1'b0;
                    drop_err_d = 1'b0;
                end
            end
            ST_INIT: begin
                if (last_path) begin
                    path_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    path_cnt_d = path_cnt_q + PIW'(1);
                end
            end
            ST_RUN: begin
                if (valid_in) begin
                    if (last_path) begin
                        path_cnt_d = '0;
                        step_cnt_d = step_cnt_q + SIW'(1);
                        if (last_step) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        path_cnt_d = path_cnt_q + PIW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Earlier results may still be emitting here; only the tagged
                // final one ends the run.
                if (vld_p2 && last_p2) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (valid_in && (state_q != ST_RUN)) begin
            drop_err_d = 1'b1;
        end
        if (vld_p2 && ovf_p2) begin
            ovf_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            path_cnt_q <= '0;
            step_cnt_q <= '0;
            ovf_err_q  <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            path_cnt_q <= path_cnt_d;
            step_cnt_q <= step_cnt_d;
            ovf_err_q  <= ovf_err_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && start) begin
            s0_q <= s0;
        end
    end

    // ---- stage 1: price read, factor and tag capture ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            price_p1  <= mem[path_cnt_q];
            factor_p1 <= exp_factor;
            path_p1   <= path_cnt_q;
            step_p1   <= step_cnt_q + SIW'(1);
            last_p1   <= last_path && last_step;
        end
    end

    // Single write port: INIT fill, otherwise stage-2 write-back. The write
    // lands on the same edge as price_out, at least one edge before the next
    // read of that path, so no bypass is required.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[path_cnt_q] <= s0_q;
        end else if (vld_p1) begin
            mem[path_p1] <= res_nxt;
        end
    end

    // ---- stage 2: multiply, round, saturate, tag ----
    fx_umul_round_sat #(
        .WIDTH (WIDTH),
        .QFRAC (QFRAC)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_i     (vld_p1),
        .a_i       (price_p1),
        .b_i       (factor_p1),
        .res_nxt_o (res_nxt),
        .res_o     (res_p2),
        .ovf_o     (ovf_p2),
        .vld_o     (vld_p2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            path_p2 <= '0;
            step_p2 <= '0;
            last_p2 <= 1'b0;
        end else if (vld_p1) begin
            path_p2 <= path_p1;
            step_p2 <= step_p1;
            last_p2 <= last_p1;
        end
    end

    assign price_out    = res_p2;
    assign path_idx_out = path_p2;
    assign step_idx_out = step_p2;
    assign valid_out    = vld_p2;
    assign done         = vld_p2 && last_p2;
    assign busy         = (state_q != ST_IDLE);
    assign overflow_err = ovf_err_q;
    assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_gbm_path_stepper.sv
module tb_gbm_path_stepper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // DUT A: 4 paths x 3 steps
    logic        start = 1'b0;
    logic [31:0] s0 = '0;
    logic        valid_in = 1'b0;
    logic [31:0] exp_factor = '0;
    logic [31:0] price_out;
    logic [1:0]  path_idx_out;
    logic [1:0]  step_idx_out;
    logic        valid_out, busy, done, overflow_err, drop_err;

    // DUT B: 2 paths x 2 steps (tightest read-after-write spacing)
    logic        start2 = 1'b0;
    logic [31:0] s02 = '0;
    logic        valid_in2 = 1'b0;
    logic [31:0] exp_factor2 = '0;
    logic [31:0] price_out2;
    logic [0:0]  path_idx_out2;
    logic [1:0]  step_idx_out2;
    logic        valid_out2, busy2, done2, overflow_err2, drop_err2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gbm_path_stepper #(.NUM_PATHS(4), .NUM_STEPS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s0(s0),
        .valid_in(valid_in), .exp_factor(exp_factor),
        .price_out(price_out), .path_idx_out(path_idx_out),
        .step_idx_out(step_idx_out), .valid_out(valid_out),
        .busy(busy), .done(done), .overflow_err(overflow_err),
        .drop_err(drop_err)
    );

    gbm_path_stepper #(.NUM_PATHS(2), .NUM_STEPS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .s0(s02),
        .valid_in(valid_in2), .exp_factor(exp_factor2),
        .price_out(price_out2), .path_idx_out(path_idx_out2),
        .step_idx_out(step_idx_out2), .valid_out(valid_out2),
        .busy(busy2), .done(done2), .overflow_err(overflow_err2),
        .drop_err(drop_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a run on DUT A, wait out INIT, stream 12 factors (fk per step k)
    // back to back and check each tagged output (ek expected per step k).
    task automatic run_a(input string tag, input logic [31:0] s0v,
                         input logic [31:0] f1, input logic [31:0] f2, input logic [31:0] f3,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] fac [3];
        logic [31:0] exp_p [3];
        fac[0] = f1; fac[1] = f2; fac[2] = f3;
        exp_p[0] = e1; exp_p[1] = e2; exp_p[2] = e3;
        start = 1'b1;
        s0 = s0v;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_ovf_clr"}, 32'(overflow_err), 32'd0);
        check({tag, "_drop_clr"}, 32'(drop_err), 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (i < 12) begin
                valid_in   = 1'b1;
                exp_factor = fac[i / 4];
            end else begin
                valid_in   = 1'b0;
                exp_factor = '0;
            end
            if (i >= 2) begin
                int j;
                j = i - 2;
                check($sformatf("%s_vld%0d", tag, j), 32'(valid_out), 32'd1);
                check($sformatf("%s_price%0d", tag, j), price_out, exp_p[j / 4]);
                check($sformatf("%s_path%0d", tag, j), 32'(path_idx_out), 32'(j % 4));
                check($sformatf("%s_step%0d", tag, j), 32'(step_idx_out), 32'(j / 4 + 1));
                check($sformatf("%s_done%0d", tag, j), 32'(done), (j == 11) ? 32'd1 : 32'd0);
            end else begin
                check($sformatf("%s_novld%0d", tag, i), 32'(valid_out), 32'd0);
            end
            @(negedge clk);
        end
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_vld_end"}, 32'(valid_out), 32'd0);
        check({tag, "_done_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("rst_price", price_out, 32'd0);
        check("rst_path", 32'(path_idx_out), 32'd0);
        check("rst_step", 32'(step_idx_out), 32'd0);
        check("rst_vld", 32'(valid_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- identity factor: 100.0 stays 100.0 ----
        run_a("unity", 32'h0064_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0064_0000, 32'h0064_0000, 32'h0064_0000);
        check("unity_ovf", 32'(overflow_err), 32'd0);
        check("unity_drop", 32'(drop_err), 32'd0);

        // ---- 1.5 per step: 150, 225, 337.5 ----
        run_a("grow", 32'h0064_0000, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000,
              32'h0096_0000, 32'h00E1_0000, 32'h0151_8000);

        // ---- rounding: 1 LSB x 0.5 rounds up to 1, then x (0.5 - 1 LSB) to 0 ----
        run_a("round", 32'h0000_0001, 32'h0000_8000, 32'h0000_7FFF, 32'h0001_0000,
              32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
        check("round_ovf", 32'(overflow_err), 32'd0);

        // ---- saturation: 32768.0 x 2.0, then all-ones x 1.0, x 0.5 ----
        run_a("sat", 32'h8000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        check("sat_ovf_sticky", 32'(overflow_err), 32'd1);
        check("sat_drop", 32'(drop_err), 32'd0);

        // ---- factor after the run is dropped ----
        valid_in = 1'b1;
        exp_factor = 32'h0001_0000;
        @(negedge clk);
        valid_in = 1'b0;
        check("drop_idle_flag", 32'(drop_err), 32'd1);
        check("drop_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("drop_idle_novld1", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("drop_idle_novld2", 32'(valid_out), 32'd0);
        check("drop_ovf_still", 32'(overflow_err), 32'd1);

        // ---- new run: errors clear on start; drop during INIT; reset mid-RUN ----
        start = 1'b1;
        s0 = 32'h0064_0000;
        @(negedge clk);
        start = 1'b0;
        check("mid_ovf_clr", 32'(overflow_err), 32'd0);
        check("mid_drop_clr", 32'(drop_err), 32'd0);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("mid_drop_init", 32'(drop_err), 32'd1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1;
            exp_factor = 32'h0001_0000;
            @(negedge clk);
        end
        check("mid_pre_vld", 32'(valid_out), 32'd1);
        check("mid_pre_path", 32'(path_idx_out), 32'd1);
        check("mid_pre_step", 32'(step_idx_out), 32'd2);
        valid_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_price", price_out, 32'd0);
        check("mid_rst_path", 32'(path_idx_out), 32'd0);
        check("mid_rst_step", 32'(step_idx_out), 32'd0);
        check("mid_rst_vld", 32'(valid_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ovf", 32'(overflow_err), 32'd0);
        check("mid_rst_drop", 32'(drop_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_a("after_rst", 32'h0032_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
              32'h0032_0000, 32'h0032_0000, 32'h0032_0000);

        // ---- DUT B: 2 paths, same path re-read two accepts after its write ----
        start2 = 1'b1;
        s02 = 32'h0064_0000;
        @(negedge clk);
        start2 = 1'b0;
        check("b_busy", 32'(busy2), 32'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            valid_in2   = (i < 4);
            exp_factor2 = (i < 4) ? 32'h0001_8000 : 32'h0;
            if (i >= 2) begin
                int j;
                j = i - 2;
                check($sformatf("b_vld%0d", j), 32'(valid_out2), 32'd1);
                check($sformatf("b_price%0d", j), price_out2,
                      (j < 2) ? 32'h0096_0000 : 32'h00E1_0000);
                check($sformatf("b_path%0d", j), 32'(path_idx_out2), 32'(j % 2));
                check($sformatf("b_step%0d", j), 32'(step_idx_out2), 32'(j / 2 + 1));
                check($sformatf("b_done%0d", j), 32'(done2), (j == 3) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
        end
        check("b_busy_fall", 32'(busy2), 32'd0);
        check("b_ovf", 32'(overflow_err2), 32'd0);
        check("b_drop", 32'(drop_err2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
